dart_word_tx: RTL and testbench
===============================

Name: dart_word_tx

Overview:
- Transmit half of the DART UART link: serialises WIDTH-bit words from Control onto RS232_TX_DATA as back-to-back 8N1 byte frames, least-significant byte first.
- Pairs with the word receiver on the same link, which reassembles the same byte order.
- Sits between Control (tx_word/tx_word_valid/tx_ack) and the RS232 TX pin, in the clock_50 domain.

Parameters:
- WIDTH, 16, word width in bits; must be a multiple of 8; NBYTES = WIDTH/8.
- BAUD_RATE, 9600, line rate in bits per second.
- CLOCK_FREQ, 50000000, clock frequency in Hz; DIVISOR = CLOCK_FREQ/BAUD_RATE, truncated (5208 at the defaults).

Ports:
- clock  in  1  system clock (clock_50).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new word (driven by dcm_locked).
- tx_data  in  WIDTH  word to send.
- tx_valid  in  1  word request; held high with tx_data stable until tx_ack.
- tx_ack  out  1  one-cycle pulse: word captured.
- tx_busy  out  1  high from the capture cycle until the last stop bit ends.
- tx_error  out  1  sticky protocol-violation flag.
- RS232_TX_DATA  out  1  serial line; idles high.

Behaviour:
- Reset (asynchronous, takes effect immediately): RS232_TX_DATA=1, tx_ack=0, tx_busy=0, tx_error=0, state IDLE, counters 0.
- Applies even mid-frame: the line returns high at once and the partial frame is abandoned.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If enable and tx_valid are both sampled high at edge N, then after edge N: shift register = tx_data, tx_ack=1 for that one cycle, tx_busy=1, line=0, state START.
  - With enable low, tx_valid is ignored and no tx_ack is issued.
- START: line=0 for DIVISOR cycles, then state DATA with bit index 0.
- DATA: line = current byte bit[idx] for DIVISOR cycles each, idx 0..7, LSB first. After idx 7 completes, state STOP.
- STOP: line=1 for DIVISOR cycles. Then:
  - if bytes remain, go to START for the next byte, with no gap;
  - after byte NBYTES-1, tx_busy=0 and state IDLE.
- Word time = NBYTES*10*DIVISOR cycles.
- IDLE lasts at least 1 cycle, so back-to-back words are separated by exactly 1 extra idle-high cycle.
- Baud counter: counts 0..DIVISOR-1 and wraps. Width is clog2(DIVISOR). Cleared on entry to START from IDLE.
- enable is sampled only in IDLE. A word already in progress completes even if enable drops.
- tx_error is set, and held until reset, when either:
  - tx_valid falls while enable=1 in IDLE without a tx_ack (request withdrawn), or
  - tx_valid is high when tx_ack is already high in the same cycle and tx_data changes in that cycle.
- tx_error has no effect on transmission.
- tx_valid high during busy: the request is held pending and accepted in the first IDLE cycle. This is not an error.

Optional Feature:
- Macro: DART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA idx 7 and STOP, lasting DIVISOR cycles. Frame becomes 11 bits; word time = NBYTES*11*DIVISOR.
- Undefined: 8N1 frames, 10 bits each, with no parity state or logic.

Decomposition:
- Shared package (dart_pkg): FSM state enum, frame-length constants (10 or 11 bits), and a clog2 helper, shared with the word receiver.
- Natural sub-module: dart_baud_gen, a DIVISOR counter with a clear input and a one-cycle tick output. It is reusable by the receiver with a half-bit offset.

Test Plan:
- Bench config: CLOCK_FREQ=160, BAUD_RATE=10, giving DIVISOR=16.
- Single word: tx_data=16'hA55A, tx_valid=1, enable=1 -> tx_ack 1 cycle after the sample. Line shows start, 5A LSB-first (0,1,0,1,1,0,1,0), stop, start, A5, stop. tx_busy high for 320 cycles.
- Back-to-back: words 16'h0001 then 16'hFFFF with tx_valid held -> second tx_ack exactly 321 cycles after the first. Line is high for exactly 1 cycle between the frames.
- Enable gating: enable=0 with tx_valid=1 for 100 cycles -> no ack, line high. Raise enable -> ack the next cycle. Drop enable mid-word -> the word completes.
- Reset mid-frame: assert reset_n low during DATA bit 3 of 16'h1234 -> line=1, tx_busy=0 immediately (asynchronously). After release, a new word 16'h00FF transmits correctly.
- Error: raise tx_valid in IDLE with enable=0, then enable=1 and drop tx_valid the same cycle -> tx_error stays 0. Then enable=1, tx_valid pulses 1 cycle and withdraws before ack -> tx_error=1, remaining high until reset.
- With DART_TX_PARITY_EN defined: byte 8'h07 -> parity bit 1 after bit 7; byte 8'h03 -> parity bit 0. Word time = 352 cycles.

Source files
------------

// File: rtl/dart_pkg.sv
// Shared DART link definitions: FSM encoding, frame lengths and a clog2 helper.
// The DART_TX_PARITY_EN build macro selects the 11-bit (8E1) frame length.
package dart_pkg;

    typedef enum logic [2:0] {
        DART_IDLE  = 3'd0,
        DART_START = 3'd1,
        DART_DATA  = 3'd2,
        DART_STOP  = 3'd3
    } dart_state_e;

    localparam int DART_FRAME_BITS_8N1 = 10;
    localparam int DART_FRAME_BITS_8E1 = 11;

`ifdef DART_TX_PARITY_EN
    localparam int DART_FRAME_BITS = DART_FRAME_BITS_8E1;
`else
    localparam int DART_FRAME_BITS = DART_FRAME_BITS_8N1;
`endif

    function automatic int dart_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dart_word_tx_if.sv
// Control-side word handshake of the DART transmitter (enable, word request, status).
interface dart_word_tx_if #(
    parameter int WIDTH = 16
) ();

    logic             enable;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ack;
    logic             tx_busy;
    logic             tx_error;

    modport master (
        output enable,
        output tx_data,
        output tx_valid,
        input  tx_ack,
        input  tx_busy,
        input  tx_error
    );

    modport slave (
        input  enable,
        input  tx_data,
        input  tx_valid,
        output tx_ack,
        output tx_busy,
        output tx_error
    );

endinterface

// File: rtl/dart_baud_gen.sv
// Bit-period counter: counts 0..DIVISOR-1 and wraps, tick pulses when count hits TICK_AT.
// The receiver sets TICK_AT to half a bit to sample mid-bit.
module dart_baud_gen
    import dart_pkg::*;
#(
    parameter int DIVISOR = 16,
    parameter int TICK_AT = DIVISOR - 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (dart_clog2(DIVISOR) < 1) ? 1 : dart_clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] TAP  = CW'(TICK_AT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == TAP);

endmodule

// File: rtl/dart_word_tx.sv
// DART word transmitter: sends WIDTH-bit words as back-to-back 8N1 bytes, LSB byte first.
// Define DART_TX_PARITY_EN to insert an even-parity bit after each byte (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for enable && tx_valid
// START  | start bit (low) for one bit period
// DATA   | data bits 0..7 of the current byte, LSB first
// PARITY | even parity of the current byte (DART_TX_PARITY_EN only)
// STOP   | stop bit (high); next byte or back to IDLE
module dart_word_tx
    import dart_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic          clock,
    input  logic          reset_n,
    dart_word_tx_if.slave ctl,
    output logic          RS232_TX_DATA
);

    localparam int NBYTES  = WIDTH / 8;
    localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
    localparam int BW      = (dart_clog2(NBYTES) < 1) ? 1 : dart_clog2(NBYTES);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    localparam logic [2:0] S_IDLE  = DART_IDLE;
    localparam logic [2:0] S_START = DART_START;
    localparam logic [2:0] S_DATA  = DART_DATA;
    localparam logic [2:0] S_STOP  = DART_STOP;
`ifdef DART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [2:0]       bit_idx;
    logic [BW-1:0]    byte_idx;
    logic             line;
    logic             ack;
    logic             busy;
    logic             err;
    logic             valid_q;
    logic             enable_q;
    logic             tick;
    logic             err_set;
    logic [7:0]       cur_byte;
    logic [2:0]       bit_nxt;

    assign cur_byte = shreg[7:0];
    assign bit_nxt  = bit_idx + 3'd1;

    dart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == S_IDLE),
        .tick    (tick)
    );

    // Withdrawal only counts when enable was high on both sides of the fall;
    // the data check compares against the word captured one edge earlier.
    assign err_set = ((state == S_IDLE) && ctl.enable && enable_q && valid_q &&
                      !ctl.tx_valid && !ack) ||
                     (ack && ctl.tx_valid && (ctl.tx_data != shreg));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            line     <= 1'b1;
            ack      <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            valid_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            ack      <= 1'b0;
            valid_q  <= ctl.tx_valid;
            enable_q <= ctl.enable;
            if (err_set) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (ctl.enable && ctl.tx_valid) begin
                        shreg    <= ctl.tx_data;
                        ack      <= 1'b1;
                        busy     <= 1'b1;
                        line     <= 1'b0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        bit_idx <= '0;
                        line    <= cur_byte[0];
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef DART_TX_PARITY_EN
                            line  <= ^cur_byte;
                            state <= S_PARITY;
`else
                            line  <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_nxt;
                            line    <= cur_byte[bit_nxt];
                        end
                    end
                end
`ifdef DART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        line  <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (byte_idx == LAST_BYTE) begin
                            busy  <= 1'b0;
                            line  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                            shreg    <= shreg >> 8;
                            line     <= 1'b0;
                            state    <= S_START;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    line  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctl.tx_ack    = ack;
    assign ctl.tx_busy   = busy;
    assign ctl.tx_error  = err;
    assign RS232_TX_DATA = line;

endmodule

// File: tb/tb_dart_word_tx.sv
// Self-checking bench for dart_word_tx at DIVISOR=16 against a frame-level line model.
module tb_dart_word_tx;

    localparam int DIV = 16;
`ifdef DART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WT      = 2 * FRAME * DIV;
    localparam int TIMEOUT = 3 * WT;

    logic clock;
    logic reset_n;
    logic RS232_TX_DATA;
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic line_log [0:WT-1];

    dart_word_tx_if #(.WIDTH(16)) ctl ();

    dart_word_tx #(
        .WIDTH      (16),
        .BAUD_RATE  (10),
        .CLOCK_FREQ (160)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctl           (ctl),
        .RS232_TX_DATA (RS232_TX_DATA)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line level k cycles after the ack cycle: start, 8 data LSB first, [parity], stop per byte.
    function automatic logic exp_line(input logic [15:0] w, input int k);
        int bitn;
        int byt;
        int pos;
        logic [7:0] b;
        bitn = k / DIV;
        byt  = bitn / FRAME;
        pos  = bitn % FRAME;
        b    = 8'(w >> (8 * byt));
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[3'(pos - 1)];
`ifdef DART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!ctl.tx_ack && lat < TIMEOUT);
        check_val("ack_seen", ctl.tx_ack, 1);
    endtask

    // Called at the ack-cycle negedge. mode 0: drop valid; 1: hold valid, new data at k=1;
    // 2: drop valid, pulse it again on the last stop cycle; 3: change data in the ack cycle.
    task automatic check_word(input logic [15:0] w, input int mode, input logic [15:0] nd,
                              input int en_drop);
        for (int k = 0; k < WT; k++) begin
            if (k > 0) @(negedge clock);
            line_log[k] = RS232_TX_DATA;
            check_val("line", RS232_TX_DATA, exp_line(w, k));
            check_val("busy", ctl.tx_busy, 1);
            check_val("ack", ctl.tx_ack, (k == 0));
            if (k == 0 && (mode == 0 || mode == 2)) ctl.tx_valid = 1'b0;
            if (k == 0 && mode == 3) ctl.tx_data = nd;
            if (k == 1 && mode == 3) ctl.tx_valid = 1'b0;
            if (k == 1 && mode == 1) ctl.tx_data = nd;
            if (k == WT - 1 && mode == 2) ctl.tx_valid = 1'b1;
            if (k == en_drop) ctl.enable = 1'b0;
        end
        @(negedge clock);
        check_val("idle_line", RS232_TX_DATA, 1);
        check_val("idle_busy", ctl.tx_busy, 0);
        if (mode == 2) ctl.tx_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int t1;
        int t2;
        int gap;
        logic [15:0] w;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        ctl.enable   = 1'b0;
        ctl.tx_valid = 1'b0;
        ctl.tx_data  = '0;
        repeat (3) @(negedge clock);
        check_val("rst_line", RS232_TX_DATA, 1);
        check_val("rst_ack", ctl.tx_ack, 0);
        check_val("rst_busy", ctl.tx_busy, 0);
        check_val("rst_err", ctl.tx_error, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // single word
        ctl.enable   = 1'b1;
        ctl.tx_data  = 16'hA55A;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        check_val("a55a_latency", lat, 1);
        check_word(16'hA55A, 0, 16'h0, -1);

        // back-to-back with valid held
        ctl.tx_data  = 16'h0001;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        t1 = cyc;
        check_word(16'h0001, 1, 16'hFFFF, -1);
        wait_ack(lat);
        t2 = cyc;
        check_val("b2b_latency", lat, 1);
        check_val("b2b_spacing", t2 - t1, WT + 1);
        check_word(16'hFFFF, 0, 16'h0, -1);
        check_val("b2b_err", ctl.tx_error, 0);

        // enable gating, then enable dropped mid-word
        ctl.enable   = 1'b0;
        ctl.tx_data  = 16'h3C96;
        ctl.tx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check_val("gate_ack", ctl.tx_ack, 0);
            check_val("gate_line", RS232_TX_DATA, 1);
        end
        ctl.enable = 1'b1;
        wait_ack(lat);
        check_val("gate_latency", lat, 1);
        check_word(16'h3C96, 0, 16'h0, 100);
        check_val("gate_err", ctl.tx_error, 0);
        ctl.enable = 1'b1;

        // parity-sensitive bytes 07 (odd) and 03 (even)
        ctl.tx_data  = 16'h0307;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        check_word(16'h0307, 0, 16'h0, -1);
`ifdef DART_TX_PARITY_EN
        check_val("parity_07", line_log[9 * DIV + DIV / 2], 1);
        check_val("parity_03", line_log[20 * DIV + DIV / 2], 0);
`endif

        // randomized words with random idle gaps
        for (int i = 0; i < 6; i++) begin
            w   = 16'($urandom);
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                check_val("gap_line", RS232_TX_DATA, 1);
                check_val("gap_busy", ctl.tx_busy, 0);
            end
            ctl.tx_data  = w;
            ctl.tx_valid = 1'b1;
            wait_ack(lat);
            check_val("rand_latency", lat, 1);
            check_word(w, 0, 16'h0, -1);
        end

        // asynchronous reset during data bit 3 of the first byte
        ctl.tx_data  = 16'h1234;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        ctl.tx_valid = 1'b0;
        for (int k = 1; k <= 4 * DIV + DIV / 2; k++) @(negedge clock);
        check_val("pre_rst_line", RS232_TX_DATA, exp_line(16'h1234, 4 * DIV + DIV / 2));
        check_val("pre_rst_busy", ctl.tx_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_line", RS232_TX_DATA, 1);
        check_val("async_rst_busy", ctl.tx_busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        ctl.tx_data  = 16'h00FF;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        check_val("post_rst_latency", lat, 1);
        check_word(16'h00FF, 0, 16'h0, -1);

        // request raised while disabled, then enable rises as valid drops: no error
        ctl.enable   = 1'b0;
        ctl.tx_valid = 1'b1;
        @(negedge clock);
        ctl.enable   = 1'b1;
        ctl.tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val("noerr_ack", ctl.tx_ack, 0);
        end
        check_val("noerr_flag", ctl.tx_error, 0);

        // pending request withdrawn at the first idle cycle: sticky error
        ctl.tx_data  = 16'h5AC3;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        check_word(16'h5AC3, 2, 16'h0, -1);
        @(negedge clock);
        check_val("withdraw_ack", ctl.tx_ack, 0);
        check_val("withdraw_err", ctl.tx_error, 1);
        repeat (20) @(negedge clock);
        check_val("withdraw_sticky", ctl.tx_error, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check_val("err_cleared", ctl.tx_error, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // data changed during the ack cycle: error, captured word still sent
        ctl.tx_data  = 16'h1111;
        ctl.tx_valid = 1'b1;
        wait_ack(lat);
        check_val("chg_err_before", ctl.tx_error, 0);
        check_word(16'h1111, 3, 16'h2222, -1);
        check_val("chg_err_after", ctl.tx_error, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
